pc_next_sel: RTL and testbench

Parametrised next-PC unit for the monocycle core: owns the PC register and selects among sequential, branch, jump, jalr, trap and return sources by fixed priority. It replaces the two-way branch/sequential select with a registered, stall-aware selector. It includes a one-entry redirect buffer so a redirect raised during a stall is not lost, plus a saved exception PC. It sits between the control unit/ALU target logic and the instruction memory address port.

---
 rtl/pc_next_sel.sv | 208 ++++++++++++++++++++
 tb/tb_pc_next_sel.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - stall-aware next-PC selector with one-entry redirect buffer
//
// Owns the PC register. Each cycle it picks the next PC by fixed priority:
// trap_req > mret > jalr > jump > branch > sequential (pc + STEP).
// A redirect raised while stalled is parked in a one-entry buffer (state PEND)
// and applied the cycle after stall falls.
//
// Optional feature macro: PC_MISALIGN_TRAP_EN
//   defined   : branch/jump/jalr targets with target[1:0] != 0 trap to TRAP_VEC
//   undefined : targets load as-is, misalign is constant 0
//
// Ports:
//   clk, reset                     rising-edge clock, async active-high reset
//   stall                          hold PC, buffer any redirect
//   branch, jump, jalr             control-flow requests
//   trap_req, mret                 exception entry / return
//   branch_target, jump_target     direct destinations
//   jalr_target                    indirect destination (bit 0 cleared here)
//   pc, epc                        registered PC and saved exception PC
//   pc_plus                        pc + STEP, combinational
//   redirect, misalign             one-cycle pulses aligned with the new pc
//   pending                        a buffered redirect is waiting
module pc_next_sel #(
    parameter int unsigned          WIDTH    = 32,
    parameter logic [WIDTH-1:0]     RESET_PC = 32'h0000_0000,
    parameter logic [WIDTH-1:0]     TRAP_VEC = 32'h0000_0100,
    parameter int unsigned          STEP     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch,
    input  logic             jump,
    input  logic             jalr,
    input  logic             trap_req,
    input  logic             mret,
    input  logic [WIDTH-1:0] branch_target,
    input  logic [WIDTH-1:0] jump_target,
    input  logic [WIDTH-1:0] jalr_target,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus,
    output logic [WIDTH-1:0] epc,
    output logic             redirect,
    output logic             pending,
    output logic             misalign
);

`ifdef PC_MISALIGN_TRAP_EN
    localparam bit MISALIGN_EN = 1'b1;
`else
    localparam bit MISALIGN_EN = 1'b0;
`endif

    typedef enum logic {RUN, PEND} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  pc_q, pc_d;
    logic [WIDTH-1:0]  epc_q, epc_d;
    logic              redirect_q, redirect_d;
    logic              misalign_q, misalign_d;

    // Buffered redirect: target, whether it is a trap, whether it is subject
    // to the alignment check, and the PC of the requesting instruction.
    logic [WIDTH-1:0]  buf_tgt_q, buf_tgt_d;
    logic              buf_trap_q, buf_trap_d;
    logic              buf_chk_q, buf_chk_d;
    logic [WIDTH-1:0]  buf_epc_q, buf_epc_d;

    // Winner among the live requests of this cycle.
    logic              req_any;
    logic [WIDTH-1:0]  req_tgt;
    logic              req_trap;
    logic              req_chk;

    // Redirect actually applied to pc this cycle.
    logic              load;
    logic [WIDTH-1:0]  ld_tgt;
    logic              ld_trap;
    logic              ld_chk;
    logic [WIDTH-1:0]  ld_epc;
    logic              mis_hit;

    assign pc_plus = pc_q + WIDTH'(STEP);

    always_comb begin
        req_any  = trap_req | mret | jalr | jump | branch;
        req_tgt  = pc_plus;
        req_trap = 1'b0;
        req_chk  = 1'b0;
        if (trap_req) begin
            req_tgt  = TRAP_VEC;
            req_trap = 1'b1;
        end else if (mret) begin
            req_tgt  = epc_q;
        end else if (jalr) begin
            req_tgt  = jalr_target & ~WIDTH'(1);
            req_chk  = 1'b1;
        end else if (jump) begin
            req_tgt  = jump_target;
            req_chk  = 1'b1;
        end else if (branch) begin
            req_tgt  = branch_target;
            req_chk  = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        epc_d      = epc_q;
        redirect_d = 1'b0;
        misalign_d = 1'b0;
        buf_tgt_d  = buf_tgt_q;
        buf_trap_d = buf_trap_q;
        buf_chk_d  = buf_chk_q;
        buf_epc_d  = buf_epc_q;
        load       = 1'b0;
        ld_tgt     = req_tgt;
        ld_trap    = req_trap;
        ld_chk     = req_chk;
        ld_epc     = pc_q;

        case (state_q)
            RUN: begin
                if (!stall) begin
                    if (req_any) begin
                        load = 1'b1;
                    end else begin
                        pc_d = pc_plus;
                    end
                end else if (req_any) begin
                    buf_tgt_d  = req_tgt;
                    buf_trap_d = req_trap;
                    buf_chk_d  = req_chk;
                    buf_epc_d  = pc_q;
                    state_d    = PEND;
                end
            end
            PEND: begin
                if (stall) begin
                    // Only a trap may displace the parked redirect.
                    if (trap_req) begin
                        buf_tgt_d  = TRAP_VEC;
                        buf_trap_d = 1'b1;
                        buf_chk_d  = 1'b0;
                        buf_epc_d  = pc_q;
                    end
                end else begin
                    state_d = RUN;
                    load    = 1'b1;
                    if (!trap_req) begin
                        ld_tgt  = buf_tgt_q;
                        ld_trap = buf_trap_q;
                        ld_chk  = buf_chk_q;
                        ld_epc  = buf_epc_q;
                    end
                end
            end
            default: state_d = RUN;
        endcase

        mis_hit = load & ld_chk & (ld_tgt[1:0] != 2'b00);

        if (load) begin
            redirect_d = 1'b1;
            pc_d       = ld_tgt;
            if (ld_trap) begin
                epc_d = ld_epc;
            end
            if (MISALIGN_EN && mis_hit) begin
                pc_d       = TRAP_VEC;
                epc_d      = ld_epc;
                misalign_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            epc_q      <= '0;
            redirect_q <= 1'b0;
            misalign_q <= 1'b0;
            buf_tgt_q  <= '0;
            buf_trap_q <= 1'b0;
            buf_chk_q  <= 1'b0;
            buf_epc_q  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            redirect_q <= redirect_d;
            misalign_q <= misalign_d;
            buf_tgt_q  <= buf_tgt_d;
            buf_trap_q <= buf_trap_d;
            buf_chk_q  <= buf_chk_d;
            buf_epc_q  <= buf_epc_d;
        end
    end

    assign pc       = pc_q;
    assign epc      = epc_q;
    assign redirect = redirect_q;
    assign misalign = misalign_q;
    assign pending  = (state_q == PEND);

endmodule

// File: tb/tb_pc_next_sel.sv
// tb/tb_pc_next_sel.sv - scoreboard testbench for pc_next_sel
module tb_pc_next_sel;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        branch = 1'b0;
    logic        jump = 1'b0;
    logic        jalr = 1'b0;
    logic        trap_req = 1'b0;
    logic        mret = 1'b0;
    logic [31:0] branch_target = '0;
    logic [31:0] jump_target = '0;
    logic [31:0] jalr_target = '0;
    logic [31:0] pc;
    logic [31:0] pc_plus;
    logic [31:0] epc;
    logic        redirect;
    logic        pending;
    logic        misalign;

    pc_next_sel dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch        (branch),
        .jump          (jump),
        .jalr          (jalr),
        .trap_req      (trap_req),
        .mret          (mret),
        .branch_target (branch_target),
        .jump_target   (jump_target),
        .jalr_target   (jalr_target),
        .pc            (pc),
        .pc_plus       (pc_plus),
        .epc           (epc),
        .redirect      (redirect),
        .pending       (pending),
        .misalign      (misalign)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        red;
        logic        pend;
        logic        mis;
        logic        chk_epc;
        logic [31:0] epc;
    } exp_t;

    exp_t sb[$];

    task automatic clear_req();
        stall    = 1'b0;
        branch   = 1'b0;
        jump     = 1'b0;
        jalr     = 1'b0;
        trap_req = 1'b0;
        mret     = 1'b0;
    endtask

    // Inputs for the cycle are already driven; queue the expected outcome,
    // let one edge pass, then retire the oldest entry against the DUT.
    task automatic cyc(input string name, input logic [31:0] pc_e, input logic red_e,
                       input logic pend_e, input logic mis_e, input logic chk_epc,
                       input logic [31:0] epc_e);
        exp_t e;
        e.name = name; e.pc = pc_e; e.red = red_e; e.pend = pend_e;
        e.mis = mis_e; e.chk_epc = chk_epc; e.epc = epc_e;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({e.name, ".pc"},       pc,                 e.pc);
        check({e.name, ".pc_plus"},  pc_plus,            e.pc + 32'd4);
        check({e.name, ".redirect"}, {31'b0, redirect},  {31'b0, e.red});
        check({e.name, ".pending"},  {31'b0, pending},   {31'b0, e.pend});
        check({e.name, ".misalign"}, {31'b0, misalign},  {31'b0, e.mis});
        if (e.chk_epc) check({e.name, ".epc"}, epc, e.epc);
        clear_req();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("rst.pc", pc, 32'h0);
        check("rst.epc", epc, 32'h0);
        check("rst.redirect", {31'b0, redirect}, 32'h0);
        check("rst.pending", {31'b0, pending}, 32'h0);
        check("rst.misalign", {31'b0, misalign}, 32'h0);
        #5 reset = 1'b0;

        cyc("seq0", 32'h4, 0, 0, 0, 1, 32'h0);
        cyc("seq1", 32'h8, 0, 0, 0, 1, 32'h0);
        cyc("seq2", 32'hC, 0, 0, 0, 1, 32'h0);

        jump = 1; jump_target = 32'h20;
        cyc("j20", 32'h20, 1, 0, 0, 1, 32'h0);
        branch = 1; branch_target = 32'h40; jump = 1; jump_target = 32'h80;
        cyc("jump_over_branch", 32'h80, 1, 0, 0, 1, 32'h0);
        cyc("after_j80", 32'h84, 0, 0, 0, 1, 32'h0);

        jump = 1; jump_target = 32'h10;
        cyc("j10", 32'h10, 1, 0, 0, 1, 32'h0);
        stall = 1; branch = 1; branch_target = 32'h60;
        cyc("pend0", 32'h10, 0, 1, 0, 1, 32'h0);
        stall = 1; jump = 1; jump_target = 32'h200;
        cyc("pend_ignore", 32'h10, 0, 1, 0, 1, 32'h0);
        stall = 1;
        cyc("pend2", 32'h10, 0, 1, 0, 1, 32'h0);
        cyc("release", 32'h60, 1, 0, 0, 1, 32'h0);
        cyc("after_rel", 32'h64, 0, 0, 0, 1, 32'h0);
        stall = 1;
        cyc("stall_idle", 32'h64, 0, 0, 0, 1, 32'h0);
        cyc("unstall_idle", 32'h68, 0, 0, 0, 1, 32'h0);

        jump = 1; jump_target = 32'h10;
        cyc("j10b", 32'h10, 1, 0, 0, 1, 32'h0);
        stall = 1; branch = 1; branch_target = 32'h60;
        cyc("pendb0", 32'h10, 0, 1, 0, 0, 32'h0);
        stall = 1; trap_req = 1;
        cyc("pend_trap", 32'h10, 0, 1, 0, 0, 32'h0);
        stall = 1;
        cyc("pendb2", 32'h10, 0, 1, 0, 0, 32'h0);
        cyc("rel_trap", 32'h100, 1, 0, 0, 1, 32'h10);

        jump = 1; jump_target = 32'h30;
        cyc("j30", 32'h30, 1, 0, 0, 1, 32'h10);
        stall = 1; jump = 1; jump_target = 32'h50;
        cyc("pendc", 32'h30, 0, 1, 0, 1, 32'h10);
        trap_req = 1;
        cyc("rel_with_trap", 32'h100, 1, 0, 0, 1, 32'h30);

        jalr = 1; jalr_target = 32'h45;
        cyc("jalr_lsb", 32'h44, 1, 0, 0, 1, 32'h30);
        jump = 1; jump_target = 32'h30;
        cyc("j30b", 32'h30, 1, 0, 0, 1, 32'h30);
        jalr = 1; jalr_target = 32'h47;
`ifdef PC_MISALIGN_TRAP_EN
        cyc("jalr_misalign", 32'h100, 1, 0, 1, 1, 32'h30);
`else
        cyc("jalr_misalign", 32'h46, 1, 0, 0, 1, 32'h30);
`endif
        jump = 1; jump_target = 32'h104;
        cyc("j104", 32'h104, 1, 0, 0, 1, 32'h30);
        mret = 1;
        cyc("mret", 32'h30, 1, 0, 0, 1, 32'h30);
        cyc("seq34", 32'h34, 0, 0, 0, 1, 32'h30);
        trap_req = 1; mret = 1; jalr = 1; jalr_target = 32'h80; jump = 1; jump_target = 32'h90;
        branch = 1; branch_target = 32'hA0;
        cyc("trap_prio", 32'h100, 1, 0, 0, 1, 32'h34);
        mret = 1; jalr = 1; jalr_target = 32'h80; jump = 1; jump_target = 32'h90;
        cyc("mret_prio", 32'h34, 1, 0, 0, 1, 32'h34);
        jalr = 1; jalr_target = 32'h81; jump = 1; jump_target = 32'h90;
        branch = 1; branch_target = 32'hA0;
        cyc("jalr_prio", 32'h80, 1, 0, 0, 1, 32'h34);

        jump = 1; jump_target = 32'hFFFF_FFFC;
        cyc("j_top", 32'hFFFF_FFFC, 1, 0, 0, 1, 32'h34);
        cyc("wrap", 32'h0, 0, 0, 0, 1, 32'h34);
        cyc("seq4", 32'h4, 0, 0, 0, 1, 32'h34);
        stall = 1; branch = 1; branch_target = 32'h60;
        cyc("pend_rst", 32'h4, 0, 1, 0, 1, 32'h34);

        #3 reset = 1'b1;
        #1;
        check("async.pc", pc, 32'h0);
        check("async.pending", {31'b0, pending}, 32'h0);
        check("async.epc", epc, 32'h0);
        check("async.redirect", {31'b0, redirect}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        cyc("post_rst", 32'h4, 0, 0, 0, 1, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
